// File: rtl/jtag_dtm_tap_pkg.sv
// Shared types for the JTAG debug transport: TAP states, IR opcodes, DMI ops.
package jtag;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'hA,
    SHIFT_IR         = 4'hB,
    EXIT1_IR         = 4'hC,
    PAUSE_IR         = 4'hD,
    EXIT2_IR         = 4'hE,
    UPDATE_IR        = 4'hF
  } jtag_state_t;

  localparam logic [5:0] IR_IDCODE = 6'h01;
  localparam logic [5:0] IR_DTMCS  = 6'h10;
  localparam logic [5:0] IR_DMI    = 6'h11;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSV   = 2'd3
  } dmi_op_t;

  typedef enum logic [1:0] {
    SEL_IDCODE,
    SEL_DTMCS,
    SEL_DMI,
    SEL_BYPASS
  } dr_sel_t;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register and tms-driven transitions only.
module jtag_tap_fsm
  import jtag::*;
(
  input  logic        tclk,
  input  logic        trst,
  input  logic        tms,
  output jtag_state_t state
);

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state <= tms ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state <= tms ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state <= tms ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state <= tms ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state <= tms ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state <= tms ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= tms ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state <= tms ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state <= tms ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state <= tms ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state <= tms ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state <= tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP with RISC-V DTM registers; DMI scans become a valid/ready request.
module jtag_dtm_tap
  import jtag::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1BEEF001,
  parameter int          IR_LEN     = 6,
  parameter int          ABITS      = 7
) (
  input  logic              tclk,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  output jtag_state_t       state,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [ABITS-1:0]  dmi_req_addr,
  output logic [31:0]       dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_resp_valid,
  input  logic [31:0]       dmi_resp_data,
  input  logic [1:0]        dmi_resp_op
);

  localparam int DW = ABITS + 34;

  logic [IR_LEN-1:0] ir, ir_shift;
  logic [DW-1:0]     dr_shift, dr_next;
  logic [ABITS-1:0]  last_addr;
  logic [31:0]       last_data;
  logic [1:0]        last_status, sticky, cap_op, upd_op;
  logic              busy, busy_eff, resp_hit, ir_side;
  logic [31:0]       dtmcs;
  dr_sel_t           sel;

  jtag_tap_fsm u_fsm (
    .tclk  (tclk),
    .trst  (trst),
    .tms   (tms),
    .state (state)
  );

  always_comb begin
    sel = SEL_BYPASS;
    if (ir == IR_LEN'(IR_IDCODE))     sel = SEL_IDCODE;
    else if (ir == IR_LEN'(IR_DTMCS)) sel = SEL_DTMCS;
    else if (ir == IR_LEN'(IR_DMI))   sel = SEL_DMI;
  end

  // Shorter registers sit in the low bits; tdi enters at their own MSB.
  always_comb begin
    dr_next = dr_shift >> 1;
    case (sel)
      SEL_DMI: dr_next[DW-1] = tdi;
      SEL_BYPASS: begin
        dr_next    = '0;
        dr_next[0] = tdi;
      end
      default: dr_next[31] = tdi;
    endcase
  end

  assign ir_side  = (state >= SELECT_IR_SCAN);
  assign tdo      = ir_side ? ir_shift[0] : dr_shift[0];
  assign tdo_en   = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign dtmcs    = {14'b0, 2'b0, 1'b0, 3'd1, sticky, 6'(ABITS), 4'd1};
  assign cap_op   = ((sticky != 2'd0) || busy) ? 2'd3 : last_status;
  assign upd_op   = dr_shift[1:0];
  // A response in the same cycle as an update retires the old request first.
  assign resp_hit = dmi_resp_valid && busy;
  assign busy_eff = busy && !dmi_resp_valid;

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ir       <= IR_LEN'(IR_IDCODE);
      ir_shift <= '0;
    end else begin
      case (state)
        TEST_LOGIC_RESET: ir       <= IR_LEN'(IR_IDCODE);
        CAPTURE_IR:       ir_shift <= IR_LEN'(1);
        SHIFT_IR:         ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
        UPDATE_IR:        ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      dr_shift <= '0;
    end else if (state == CAPTURE_DR) begin
      case (sel)
        SEL_IDCODE: dr_shift <= DW'(IDCODE_VAL);
        SEL_DTMCS:  dr_shift <= DW'(dtmcs);
        SEL_DMI:    dr_shift <= {last_addr, last_data, cap_op};
        default:    dr_shift <= '0;
      endcase
    end else if (state == SHIFT_DR) begin
      dr_shift <= dr_next;
    end
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      dmi_req_valid <= 1'b0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= '0;
      last_addr     <= '0;
      last_data     <= '0;
      last_status   <= '0;
      sticky        <= '0;
      busy          <= 1'b0;
    end else begin
      if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
      if (resp_hit) begin
        busy        <= 1'b0;
        last_status <= dmi_resp_op;
        if (dmi_req_op == DMI_READ) last_data <= dmi_resp_data;
      end
      if (state == TEST_LOGIC_RESET) sticky <= '0;
      if (state == UPDATE_DR && sel == SEL_DMI &&
          (upd_op == DMI_READ || upd_op == DMI_WRITE)) begin
        if (busy_eff) begin
          sticky <= 2'd3;
        end else if (sticky == 2'd0) begin
          dmi_req_valid <= 1'b1;
          dmi_req_addr  <= dr_shift[DW-1:34];
          dmi_req_data  <= dr_shift[33:2];
          dmi_req_op    <= upd_op;
          last_addr     <= dr_shift[DW-1:34];
          last_data     <= dr_shift[33:2];
          busy          <= 1'b1;
        end
      end
      // Hard reset is evaluated last so it overrides a same-cycle handshake.
      if (state == UPDATE_DR && sel == SEL_DTMCS) begin
        if (dr_shift[16]) sticky <= '0;
        if (dr_shift[17]) begin
          dmi_req_valid <= 1'b0;
          busy          <= 1'b0;
          sticky        <= '0;
        end
      end
    end
  end

endmodule
